// File: rtl/fifo_pkt_pkg.sv
// Shared definitions for the packet FIFO writer/reader pair: one-hot state
// codes, default sync bytes and the fixed header length.
package fifo_pkt_pkg;

  localparam logic [7:0] ST_IDLE  = 8'h01;
  localparam logic [7:0] ST_SYNC0 = 8'h02;
  localparam logic [7:0] ST_SYNC1 = 8'h04;
  localparam logic [7:0] ST_PARTH = 8'h08;
  localparam logic [7:0] ST_PARTL = 8'h10;
  localparam logic [7:0] ST_DATA  = 8'h20;
  localparam logic [7:0] ST_LAST  = 8'h40;
  localparam logic [7:0] ST_ERR   = 8'h80;

  localparam logic [7:0]  HEAD0_DEF = 8'h55;
  localparam logic [7:0]  HEAD1_DEF = 8'hAA;

  // Sync word (2 bytes) plus part field (2 bytes).
  localparam logic [11:0] HDR_LEN = 12'd4;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry byte buffer between the FIFO read pipeline and the downstream
// valid/ready port. The valid flag is a register; the data word is held
// steady while a byte waits for ready.
module fifo_rd_skid (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic [1:0] count
);

  logic [7:0] mem_r [2];
  logic       wr_ptr_r;
  logic       rd_ptr_r;
  logic [1:0] cnt_r;
  logic [1:0] cnt_next_s;
  logic       valid_r;
  logic       pop_s;
  logic       push_s;

  assign pop_s    = valid_r & rd_ready;
  // The issuer never overfills; the guard keeps a full buffer intact anyway.
  assign push_s   = wr_en & ((cnt_r != 2'd2) | pop_s);
  assign rd_data  = mem_r[rd_ptr_r];
  assign rd_valid = valid_r;
  assign count    = cnt_r;

  // Occupancy update: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    cnt_next_s = cnt_r;
    case ({push_s, pop_s})
      2'b10:   cnt_next_s = cnt_r + 2'd1;
      2'b01:   cnt_next_s = cnt_r - 2'd1;
      default: cnt_next_s = cnt_r;
    endcase
  end

  // Storage, pointers and the registered valid flag; flush empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_r[0] <= 8'h00;
      mem_r[1] <= 8'h00;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
      valid_r  <= 1'b0;
    end else if (flush) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
      valid_r  <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      cnt_r   <= cnt_next_s;
      valid_r <= (cnt_next_s != 2'd0);
    end
  end

endmodule

// File: rtl/fifo_read_pkt.sv
// Packet reader: pops bytes from a standard FIFO, hunts for the sync word,
// latches the part field and streams the payload on a valid/ready port.
module fifo_read_pkt
  import fifo_pkt_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 1024,
  parameter logic [7:0] HEAD0       = HEAD0_DEF,
  parameter logic [7:0] HEAD1       = HEAD1_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  output logic        fifo_rden,
  input  logic [7:0]  fifo_rxd,
  input  logic        fs,
  output logic        fd,
  input  logic [11:0] data_len,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        dout_last,
  output logic [15:0] part_out,
  output logic        err,
  output logic [7:0]  so
);

  localparam logic [11:0] TMO_LAST = 12'(TIMEOUT_CYC - 1);

  logic [7:0]  state_r;
  logic [7:0]  state_next_s;
  logic [11:0] len_r;
  logic [11:0] req_cnt_r;
  logic [11:0] tx_cnt_r;
  logic [11:0] tmo_cnt_r;
  logic [15:0] part_r;
  logic        rd_pend_r;
  logic        fd_r;
  logic        err_r;

  logic [11:0] len_m4_s;
  logic [11:0] len_m5_s;
  logic [1:0]  skid_cnt_s;
  logic [1:0]  occ_s;
  logic        want_s;
  logic        rd_acc_s;
  logic        tmo_act_s;
  logic        tmo_inc_s;
  logic        tmo_hit_s;
  logic        tx_fire_s;
  logic        push_s;
  logic        flush_s;

  assign len_m4_s  = len_r - HDR_LEN;
  assign len_m5_s  = len_r - 12'd5;
  // Bytes already committed to the buffer: stored plus one possibly in flight.
  assign occ_s     = skid_cnt_s + {1'b0, rd_pend_r};
  assign rd_acc_s  = want_s & ~fifo_empty;
  assign fifo_rden = rd_acc_s;
  assign tmo_inc_s = tmo_act_s & want_s & fifo_empty;
  assign tmo_hit_s = tmo_inc_s & (tmo_cnt_r == TMO_LAST);
  assign tx_fire_s = dout_valid & dout_ready;
  assign push_s    = rd_pend_r & (state_r == ST_DATA);
  assign flush_s   = (state_next_s == ST_IDLE) | (state_next_s == ST_ERR);
  assign dout_last = dout_valid & (state_r == ST_DATA) & (tx_cnt_r == len_m5_s);
  assign part_out  = part_r;
  assign fd        = fd_r;
  assign err       = err_r;
  assign so        = state_r;

  // Read-issue decision: header bytes one at a time, payload pipelined.
  always_comb begin
    want_s    = 1'b0;
    tmo_act_s = 1'b0;
    case (state_r)
      ST_SYNC0: begin
        want_s    = fs & ~rd_pend_r;
        tmo_act_s = 1'b0;
      end
      ST_SYNC1, ST_PARTH, ST_PARTL: begin
        want_s    = fs & ~rd_pend_r;
        tmo_act_s = 1'b1;
      end
      ST_DATA: begin
        want_s    = fs & (req_cnt_r < len_m4_s) & (occ_s < 2'd2);
        tmo_act_s = 1'b1;
      end
      default: begin
        want_s    = 1'b0;
        tmo_act_s = 1'b0;
      end
    endcase
  end

  // Next-state logic; fs dropping mid-packet aborts quietly to IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fs) state_next_s = (data_len < HDR_LEN) ? ST_ERR : ST_SYNC0;
        else    state_next_s = ST_IDLE;
      end
      ST_SYNC0: begin
        if (!fs)                              state_next_s = ST_IDLE;
        else if (rd_pend_r && fifo_rxd == HEAD0) state_next_s = ST_SYNC1;
        else                                  state_next_s = ST_SYNC0;
      end
      ST_SYNC1: begin
        if (!fs)                   state_next_s = ST_IDLE;
        else if (tmo_hit_s)        state_next_s = ST_ERR;
        else if (!rd_pend_r)       state_next_s = ST_SYNC1;
        else if (fifo_rxd == HEAD1) state_next_s = ST_PARTH;
        else if (fifo_rxd == HEAD0) state_next_s = ST_SYNC1;
        else                       state_next_s = ST_SYNC0;
      end
      ST_PARTH: begin
        if (!fs)            state_next_s = ST_IDLE;
        else if (tmo_hit_s) state_next_s = ST_ERR;
        else if (rd_pend_r) state_next_s = ST_PARTL;
        else                state_next_s = ST_PARTH;
      end
      ST_PARTL: begin
        if (!fs)            state_next_s = ST_IDLE;
        else if (tmo_hit_s) state_next_s = ST_ERR;
        else if (rd_pend_r) state_next_s = (len_r == HDR_LEN) ? ST_LAST : ST_DATA;
        else                state_next_s = ST_PARTL;
      end
      ST_DATA: begin
        if (!fs)                                    state_next_s = ST_IDLE;
        else if (tmo_hit_s)                         state_next_s = ST_ERR;
        else if (tx_fire_s && tx_cnt_r == len_m5_s) state_next_s = ST_LAST;
        else                                        state_next_s = ST_DATA;
      end
      ST_LAST: state_next_s = fs ? ST_LAST : ST_IDLE;
      ST_ERR:  state_next_s = fs ? ST_ERR : ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register with registered done/error flags decoded from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      fd_r    <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      fd_r    <= (state_next_s == ST_LAST);
      err_r   <= (state_next_s == ST_ERR);
    end
  end

  // Length latch, request/transmit/timeout counters, in-flight flag, part field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r     <= 12'd0;
      req_cnt_r <= 12'd0;
      tx_cnt_r  <= 12'd0;
      tmo_cnt_r <= 12'd0;
      rd_pend_r <= 1'b0;
      part_r    <= 16'h0000;
    end else begin
      rd_pend_r <= rd_acc_s;
      if (state_r == ST_IDLE) begin
        req_cnt_r <= 12'd0;
        tx_cnt_r  <= 12'd0;
        tmo_cnt_r <= 12'd0;
        if (fs) len_r <= data_len;
      end else begin
        if (rd_acc_s && state_r == ST_DATA) req_cnt_r <= req_cnt_r + 12'd1;
        if (tx_fire_s)                      tx_cnt_r  <= tx_cnt_r + 12'd1;
        if (rd_acc_s)                       tmo_cnt_r <= 12'd0;
        else if (tmo_inc_s)                 tmo_cnt_r <= tmo_cnt_r + 12'd1;
      end
      if (rd_pend_r && state_r == ST_PARTH) part_r[15:8] <= fifo_rxd;
      if (rd_pend_r && state_r == ST_PARTL) part_r[7:0]  <= fifo_rxd;
    end
  end

  fifo_rd_skid u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush_s),
    .wr_en    (push_s),
    .wr_data  (fifo_rxd),
    .rd_ready (dout_ready),
    .rd_data  (dout),
    .rd_valid (dout_valid),
    .count    (skid_cnt_s)
  );

endmodule

// File: tb/tb_fifo_read_pkt.sv
// Bench for fifo_read_pkt: behavioural FIFO model, constant vector table,
// hand sequences for multi-cycle corners and randomized packets.
module tb_fifo_read_pkt;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic        fifo_rden;
  logic [7:0]  fifo_rxd;
  logic        fs;
  logic        fd;
  logic [11:0] data_len;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;
  logic [15:0] part_out;
  logic        err;
  logic [7:0]  so;

  always #5 clk = ~clk;

  fifo_read_pkt dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rden(fifo_rden),
    .fifo_rxd(fifo_rxd), .fs(fs), .fd(fd), .data_len(data_len), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
    .part_out(part_out), .err(err), .so(so)
  );

  typedef struct packed {
    logic [11:0] len;
    logic [95:0] bytes;     // first byte in the top bits
    int          nb;
    logic [15:0] exp_part;
    int          exp_np;
    logic [31:0] exp_pay;   // first payload byte in the top bits
    logic        exp_err;
    logic        exp_fd;
    int          exp_pops;
  } vec_t;

  vec_t vecs [4];

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] fifo_q [$];
  logic [7:0] rx_q   [$];
  bit         last_q [$];
  int pops, pay_start, empty_ticks, rden_empty_viol, occ_viol;
  bit force_empty, rand_ready, rand_empty;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: sync sits at the first 0x55 directly followed by 0xAA.
  function automatic int find_sync(input logic [7:0] s [$]);
    for (int i = 0; i + 1 < s.size(); i++)
      if (s[i] == 8'h55 && s[i+1] == 8'hAA) return i;
    return -1;
  endfunction

  // One clock: drive at negedge, sample just before the edge, update FIFO after.
  task automatic tick();
    logic s_rden, s_empty, s_valid, s_ready, s_last;
    logic [7:0] s_dout;
    fifo_empty = (fifo_q.size() == 0) || force_empty || (rand_empty && ($urandom_range(0, 3) == 0));
    dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    s_rden = fifo_rden; s_empty = fifo_empty; s_valid = dout_valid;
    s_ready = dout_ready; s_dout = dout; s_last = dout_last;
    if (s_empty) empty_ticks++;
    if (s_rden && s_empty) rden_empty_viol++;
    if (s_rden && !s_empty && pops >= pay_start && (pops - pay_start) - rx_q.size() >= 2)
      occ_viol++;
    @(posedge clk);
    #1;
    if (s_rden && !s_empty) begin
      fifo_rxd = fifo_q.pop_front();
      pops++;
    end
    if (s_valid && s_ready) begin
      rx_q.push_back(s_dout);
      last_q.push_back(s_last);
    end
    @(negedge clk);
  endtask

  // Start a transaction on the current FIFO contents and run until fd/err or budget.
  task automatic run_pkt(input logic [11:0] len, input int stall_after);
    int sy;
    sy = find_sync(fifo_q);
    pay_start = (sy < 0) ? (1 << 20) : sy + 4;
    pops = 0; empty_ticks = 0; rden_empty_viol = 0; occ_viol = 0;
    rx_q.delete(); last_q.delete(); force_empty = 1'b0;
    fs = 1'b1; data_len = len;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (stall_after >= 0 && pops >= pay_start + stall_after) force_empty = 1'b1;
      if (fd || err) break;
    end
  endtask

  task automatic end_pkt(input string nm);
    fs = 1'b0; force_empty = 1'b0; rand_ready = 1'b0; rand_empty = 1'b0;
    tick(); tick();
    check({nm, "_idle"}, so, 8'h01);
    check({nm, "_err_clr"}, err, 1'b0);
  endtask

  task automatic verify(input string nm, input logic [7:0] ep [$], input logic [15:0] epart,
                        input bit chk_part, input bit eerr, input bit efd, input int epops);
    int nl;
    check({nm, "_err"}, err, eerr);
    check({nm, "_fd"}, fd, efd);
    if (chk_part) check({nm, "_part"}, part_out, epart);
    check({nm, "_npay"}, rx_q.size(), ep.size());
    check({nm, "_pops"}, pops, epops);
    for (int i = 0; i < ep.size(); i++)
      check($sformatf("%s_pay%0d", nm, i), (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hDEAD, ep[i]);
    nl = 0;
    foreach (last_q[i]) if (last_q[i]) nl++;
    check({nm, "_nlast"}, nl, (ep.size() > 0) ? 1 : 0);
    if (ep.size() > 0 && last_q.size() == ep.size())
      check({nm, "_lastpos"}, last_q[ep.size()-1], 1'b1);
    check({nm, "_rden_empty"}, rden_empty_viol, 0);
    check({nm, "_occupancy"}, occ_viol, 0);
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    logic [95:0] b;
    logic [31:0] p;
    logic [7:0] ep [$];
    string nm;
    v = vecs[k]; b = v.bytes; p = v.exp_pay;
    nm = $sformatf("vec%0d", k);
    fifo_q.delete();
    for (int i = 0; i < v.nb; i++) fifo_q.push_back(b[95 - 8*i -: 8]);
    for (int i = 0; i < v.exp_np; i++) ep.push_back(p[31 - 8*i -: 8]);
    run_pkt(v.len, -1);
    verify(nm, ep, v.exp_part, !v.exp_err, v.exp_err, v.exp_fd, v.exp_pops);
    end_pkt(nm);
  endtask

  initial begin
    vecs[0] = '{len: 12'd8, bytes: 96'h55AA1234_04050607_00000000, nb: 8, exp_part: 16'h1234,
                exp_np: 4, exp_pay: 32'h04050607, exp_err: 1'b0, exp_fd: 1'b1, exp_pops: 8};
    vecs[1] = '{len: 12'd6, bytes: 96'h005555AA_12340A0B_00000000, nb: 8, exp_part: 16'h1234,
                exp_np: 2, exp_pay: 32'h0A0B0000, exp_err: 1'b0, exp_fd: 1'b1, exp_pops: 8};
    vecs[2] = '{len: 12'd4, bytes: 96'h55AABEEF_00000000_00000000, nb: 4, exp_part: 16'hBEEF,
                exp_np: 0, exp_pay: 32'h0, exp_err: 1'b0, exp_fd: 1'b1, exp_pops: 4};
    vecs[3] = '{len: 12'd2, bytes: 96'h55AA0102_00000000_00000000, nb: 4, exp_part: 16'h0,
                exp_np: 0, exp_pay: 32'h0, exp_err: 1'b1, exp_fd: 1'b0, exp_pops: 0};

    rst = 1'b1; fs = 1'b0; data_len = 12'd0; dout_ready = 1'b0; fifo_empty = 1'b1;
    fifo_rxd = 8'h00; force_empty = 1'b0; rand_ready = 1'b0; rand_empty = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_so", so, 8'h01);
    check("rst_outs", {fd, err, dout_valid, dout_last, fifo_rden}, 5'b0);
    check("rst_part", part_out, 16'h0000);
    check("rst_dout", dout, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Constant vector table: normal, garbage-before-sync, len=4, len=2.
    for (int k = 0; k < 4; k++) run_vec(k);

    // Backpressure: 32-byte payload 04..23 under random ready.
    begin
      logic [7:0] ep [$];
      fifo_q = '{8'h55, 8'hAA, 8'h00, 8'h01};
      for (int i = 4; i < 36; i++) begin
        fifo_q.push_back(8'(i));
        ep.push_back(8'(i));
      end
      rand_ready = 1'b1;
      run_pkt(12'd36, -1);
      verify("bp", ep, 16'h0001, 1'b1, 1'b0, 1'b1, 36);
      end_pkt("bp");
    end

    // Underrun: FIFO dries up after two payload bytes.
    begin
      fifo_q = '{8'h55, 8'hAA, 8'h77, 8'h88};
      for (int i = 0; i < 12; i++) fifo_q.push_back(8'(8'h40 + i));
      run_pkt(12'd16, 2);
      check("ur_err", err, 1'b1);
      check("ur_fd", fd, 1'b0);
      check("ur_npay", rx_q.size(), 2);
      check("ur_ticks_ok", (empty_ticks >= 1024 && empty_ticks <= 1030), 1'b1);
      check("ur_rden_empty", rden_empty_viol, 0);
      end_pkt("ur");
    end

    // Reset in the middle of the payload, then a clean packet.
    begin
      fifo_q = '{8'h55, 8'hAA, 8'h12, 8'h34};
      for (int i = 0; i < 16; i++) fifo_q.push_back(8'(i));
      pay_start = 4; pops = 0; rx_q.delete(); last_q.delete();
      fs = 1'b1; data_len = 12'd20;
      for (int c = 0; c < 60 && so != 8'h20; c++) tick();
      tick(); tick();
      check("mr_in_data", so, 8'h20);
      rst = 1'b1;
      #1;
      check("mr_so", so, 8'h01);
      check("mr_outs", {fd, err, dout_valid, dout_last, fifo_rden}, 5'b0);
      check("mr_part", part_out, 16'h0000);
      fs = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_vec(0);
    end

    // Randomized packets against the sync-search reference.
    for (int r = 0; r < 6; r++) begin
      logic [7:0] pkt [$];
      logic [7:0] ep [$];
      int np, sy;
      np = $urandom_range(1, 40);
      pkt.delete(); ep.delete();
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) pkt.push_back(8'($urandom_range(0, 8'h54)));
      pkt.push_back(8'h55); pkt.push_back(8'hAA);
      pkt.push_back(8'($urandom)); pkt.push_back(8'($urandom));
      for (int i = 0; i < np; i++) pkt.push_back(8'($urandom));
      sy = find_sync(pkt);
      for (int i = 0; i < np; i++) ep.push_back(pkt[sy + 4 + i]);
      fifo_q = pkt;
      rand_ready = 1'b1; rand_empty = 1'b1;
      run_pkt(12'(np + 4), -1);
      verify($sformatf("rnd%0d", r), ep, {pkt[sy+2], pkt[sy+3]}, 1'b1, 1'b0, 1'b1, sy + 4 + np);
      end_pkt($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
